// File: rtl/src_datapath.sv
// ----------------------------------------------------------------------------
// src_datapath
// 32-bit single-bus datapath for the Mini-SRC CPU: sixteen general registers,
// the special registers (PC, IR, MAR, MDR, HI, LO, Y, Z, In_Port) and the ALU.
// An external control unit sequences register transfers with one-hot in/out
// strobes; each transfer completes on one rising clock edge.
//
// Ports
//   i_clock          rising-edge clock for every register
//   i_clear          async active-low clear of every register
//   i_r_in[15:0]     bit n loads Rn from the bus
//   i_r_out[15:0]    bit n drives Rn onto the bus
//   i_hi_in/i_lo_in/i_pc_in/i_ir_in/i_mar_in/i_y_in   load from the bus
//   i_zhigh_in/i_zlow_in  load Z[63:32] / Z[31:0] from the bus
//   i_z_in           load all of Z from the ALU result (wins over zhigh/zlow)
//   i_mdr_in         load MDR from the MDR mux
//   i_read           MDR mux select: 1 = i_mdatain, 0 = bus
//   i_in_port_in     load In_Port from the bus
//   i_c_out_in       reserved, no effect
//   i_hi_out/i_lo_out/i_zhigh_out/i_zlow_out/i_pc_out/i_mdr_out/
//   i_in_port_out/i_c_out   drive that source onto the bus
//   i_mdatain[31:0]  memory read data
//   i_alu_control[3:0] ALU opcode
//   o_out_portout[31:0] contents of the In_Port register
// ----------------------------------------------------------------------------
module src_datapath (
    input  logic        i_clock,
    input  logic        i_clear,
    input  logic [15:0] i_r_in,
    input  logic [15:0] i_r_out,
    input  logic        i_hi_in,
    input  logic        i_lo_in,
    input  logic        i_pc_in,
    input  logic        i_ir_in,
    input  logic        i_mar_in,
    input  logic        i_y_in,
    input  logic        i_zhigh_in,
    input  logic        i_zlow_in,
    input  logic        i_z_in,
    input  logic        i_mdr_in,
    input  logic        i_read,
    input  logic        i_in_port_in,
    input  logic        i_c_out_in,
    input  logic        i_hi_out,
    input  logic        i_lo_out,
    input  logic        i_zhigh_out,
    input  logic        i_zlow_out,
    input  logic        i_pc_out,
    input  logic        i_mdr_out,
    input  logic        i_in_port_out,
    input  logic        i_c_out,
    input  logic [31:0] i_mdatain,
    input  logic [3:0]  i_alu_control,
    output logic [31:0] o_out_portout
);

    logic [31:0] r_gpr [16];
    logic [31:0] r_hi, r_lo, r_pc, r_ir, r_mar, r_y, r_mdr, r_in_port;
    logic [63:0] r_z;

    logic [31:0] w_bus;
    logic [31:0] w_c;
    logic [31:0] w_mdr_d;
    logic [63:0] w_alu;

    // MAR has no reader inside this block and Coutin is reserved.
    logic        w_unused;
    assign w_unused = ^{r_mar, i_c_out_in, r_ir[31:19]};

    assign w_c     = {{13{r_ir[18]}}, r_ir[18:0]};
    assign w_mdr_d = i_read ? i_mdatain : w_bus;

    // Later assignments override earlier ones, so the list runs from the
    // lowest-priority source (C) up to R0.
    always_comb begin
        w_bus = '0;
        if (i_c_out)       w_bus = w_c;
        if (i_in_port_out) w_bus = r_in_port;
        if (i_mdr_out)     w_bus = r_mdr;
        if (i_pc_out)      w_bus = r_pc;
        if (i_zlow_out)    w_bus = r_z[31:0];
        if (i_zhigh_out)   w_bus = r_z[63:32];
        if (i_lo_out)      w_bus = r_lo;
        if (i_hi_out)      w_bus = r_hi;
        for (int i = 15; i >= 0; i--) begin
            if (i_r_out[i]) w_bus = r_gpr[i];
        end
    end

    // ALU: A = Y, B = bus
    logic [4:0]  w_sh;
    logic [63:0] w_dbl_r;
    logic [63:0] w_dbl_l;
    logic signed [63:0] w_mul;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quo, w_rem;

    assign w_sh    = w_bus[4:0];
    assign w_dbl_r = {r_y, r_y} >> w_sh;
    assign w_dbl_l = {r_y, r_y} << w_sh;
    assign w_mul   = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});

    // Signed divide done on magnitudes so the most-negative dividend has a
    // well-defined (wrapped) result; remainder takes the dividend's sign.
    assign w_a_neg = r_y[31];
    assign w_b_neg = w_bus[31];
    assign w_a_mag = w_a_neg ? (32'd0 - r_y)   : r_y;
    assign w_b_mag = w_b_neg ? (32'd0 - w_bus) : w_bus;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_alu = '0;
        case (i_alu_control)
            4'd0:  w_alu = {32'd0, r_y + w_bus};
            4'd1:  w_alu = {32'd0, r_y - w_bus};
            4'd2:  w_alu = {32'd0, r_y & w_bus};
            4'd3:  w_alu = {32'd0, r_y | w_bus};
            4'd4:  w_alu = {32'd0, 32'd0 - w_bus};
            4'd5:  w_alu = {32'd0, ~w_bus};
            4'd6:  w_alu = {32'd0, r_y >> w_sh};
            4'd7:  w_alu = {32'd0, $unsigned($signed(r_y) >>> w_sh)};
            4'd8:  w_alu = {32'd0, r_y << w_sh};
            4'd9:  w_alu = {32'd0, w_dbl_r[31:0]};
            4'd10: w_alu = {32'd0, w_dbl_l[63:32]};
            4'd11: w_alu = w_mul;
            4'd12: w_alu = (w_bus == 32'd0) ? {r_y, 32'hFFFF_FFFF} : {w_rem, w_quo};
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pc      <= '0;
            r_ir      <= '0;
            r_mar     <= '0;
            r_y       <= '0;
            r_mdr     <= '0;
            r_in_port <= '0;
            r_z       <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i_r_in[i]) r_gpr[i] <= w_bus;
            end
            if (i_hi_in)      r_hi      <= w_bus;
            if (i_lo_in)      r_lo      <= w_bus;
            if (i_pc_in)      r_pc      <= w_bus;
            if (i_ir_in)      r_ir      <= w_bus;
            if (i_mar_in)     r_mar     <= w_bus;
            if (i_y_in)       r_y       <= w_bus;
            if (i_mdr_in)     r_mdr     <= w_mdr_d;
            if (i_in_port_in) r_in_port <= w_bus;
            if (i_z_in) begin
                r_z <= w_alu;
            end else begin
                if (i_zhigh_in) r_z[63:32] <= w_bus;
                if (i_zlow_in)  r_z[31:0]  <= w_bus;
            end
        end
    end

    assign o_out_portout = r_in_port;

endmodule

// File: tb/tb_src_datapath.sv
module tb_src_datapath;

    logic        i_clock = 1'b0;
    logic        i_clear = 1'b0;
    logic [15:0] i_r_in = '0, i_r_out = '0;
    logic i_hi_in = 0, i_lo_in = 0, i_pc_in = 0, i_ir_in = 0, i_mar_in = 0, i_y_in = 0;
    logic i_zhigh_in = 0, i_zlow_in = 0, i_z_in = 0, i_mdr_in = 0, i_read = 0;
    logic i_in_port_in = 0, i_c_out_in = 0;
    logic i_hi_out = 0, i_lo_out = 0, i_zhigh_out = 0, i_zlow_out = 0, i_pc_out = 0;
    logic i_mdr_out = 0, i_in_port_out = 0, i_c_out = 0;
    logic [31:0] i_mdatain = '0;
    logic [3:0]  i_alu_control = '0;
    logic [31:0] o_out_portout;

    src_datapath dut (
        .i_clock(i_clock), .i_clear(i_clear),
        .i_r_in(i_r_in), .i_r_out(i_r_out),
        .i_hi_in(i_hi_in), .i_lo_in(i_lo_in), .i_pc_in(i_pc_in), .i_ir_in(i_ir_in),
        .i_mar_in(i_mar_in), .i_y_in(i_y_in), .i_zhigh_in(i_zhigh_in), .i_zlow_in(i_zlow_in),
        .i_z_in(i_z_in), .i_mdr_in(i_mdr_in), .i_read(i_read), .i_in_port_in(i_in_port_in),
        .i_c_out_in(i_c_out_in), .i_hi_out(i_hi_out), .i_lo_out(i_lo_out),
        .i_zhigh_out(i_zhigh_out), .i_zlow_out(i_zlow_out), .i_pc_out(i_pc_out),
        .i_mdr_out(i_mdr_out), .i_in_port_out(i_in_port_out), .i_c_out(i_c_out),
        .i_mdatain(i_mdatain), .i_alu_control(i_alu_control), .o_out_portout(o_out_portout)
    );

    always #5 i_clock = ~i_clock;

    // source mask bits: 0-15 Rn, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 In_Port, 23 C
    localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_MDR = 21, S_INP = 22, S_C = 23;
    // dest mask bits: 0-15 Rn, 16 HI, 17 LO, 18 PC, 19 IR, 20 MAR, 21 Y, 22 Zhigh, 23 Zlow, 24 Z(ALU), 25 MDR, 26 In_Port
    localparam int D_HI = 16, D_LO = 17, D_PC = 18, D_IR = 19, D_MAR = 20, D_Y = 21;
    localparam int D_ZH = 22, D_ZL = 23, D_Z = 24, D_MDR = 25, D_INP = 26;

    // reference model state
    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_y, m_mdr, m_inp;
    logic [63:0] m_z;

    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [23:0] sb(input int k);
        sb = 24'(1) << k;
    endfunction

    function automatic logic [26:0] db(input int k);
        db = 27'(1) << k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        m_hi = 0; m_lo = 0; m_pc = 0; m_ir = 0; m_mar = 0; m_y = 0; m_mdr = 0; m_inp = 0; m_z = 0;
    endtask

    function automatic logic [31:0] source_val(input int k);
        int c;
        if (k < 16) return m_gpr[k];
        case (k)
            S_HI:  return m_hi;
            S_LO:  return m_lo;
            S_ZH:  return m_z[63:32];
            S_ZL:  return m_z[31:0];
            S_PC:  return m_pc;
            S_MDR: return m_mdr;
            S_INP: return m_inp;
            default: begin
                // C: IR[18:0] read as a signed 19-bit number
                c = int'(m_ir[18:0]);
                if (m_ir[18]) c = c - (1 << 19);
                return 32'(c);
            end
        endcase
    endfunction

    function automatic logic [31:0] model_bus(input logic [23:0] s);
        for (int k = 0; k < 24; k++) if (s[k]) return source_val(k);
        return 32'd0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        longint sa, sbv, q, r;
        n   = int'(b[4:0]);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            4'd0:  return {32'd0, 32'(a + b)};
            4'd1:  return {32'd0, 32'(a - b)};
            4'd2:  return {32'd0, a & b};
            4'd3:  return {32'd0, a | b};
            4'd4:  return {32'd0, 32'(-sbv)};
            4'd5:  return {32'd0, ~b};
            4'd6:  return {32'd0, 32'(a / (64'd1 << n))};
            4'd7:  return {32'd0, 32'((sa - ((sa % (64'sd1 <<< n) + (64'sd1 <<< n)) % (64'sd1 <<< n))) / (64'sd1 <<< n))};
            4'd8:  return {32'd0, 32'(64'(a) * (64'd1 << n))};
            4'd9:  return (n == 0) ? {32'd0, a} : {32'd0, (a >> n) | (a << (32 - n))};
            4'd10: return (n == 0) ? {32'd0, a} : {32'd0, (a << n) | (a >> (32 - n))};
            4'd11: return 64'(sa * sbv);
            4'd12: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {32'(r), 32'(q)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // One register-transfer cycle. When In_Port is loaded, the expected
    // Out_Portout value is queued for the monitor.
    task automatic step(input logic [23:0] s, input logic [26:0] d, input logic [3:0] op,
                        input logic rd, input logic [31:0] md,
                        input logic use_exp, input logic [31:0] expv);
        logic [31:0] b;
        logic [63:0] alu;
        @(negedge i_clock);
        i_r_out = s[15:0];
        i_hi_out = s[S_HI]; i_lo_out = s[S_LO]; i_zhigh_out = s[S_ZH]; i_zlow_out = s[S_ZL];
        i_pc_out = s[S_PC]; i_mdr_out = s[S_MDR]; i_in_port_out = s[S_INP]; i_c_out = s[S_C];
        i_r_in = d[15:0];
        i_hi_in = d[D_HI]; i_lo_in = d[D_LO]; i_pc_in = d[D_PC]; i_ir_in = d[D_IR];
        i_mar_in = d[D_MAR]; i_y_in = d[D_Y]; i_zhigh_in = d[D_ZH]; i_zlow_in = d[D_ZL];
        i_z_in = d[D_Z]; i_mdr_in = d[D_MDR]; i_in_port_in = d[D_INP];
        i_alu_control = op; i_read = rd; i_mdatain = md;
        i_c_out_in = 1'($urandom_range(0, 1));
        b   = model_bus(s);
        alu = model_alu(op, m_y, b);
        if (d[D_INP]) exp_q.push_back(use_exp ? expv : b);
        @(posedge i_clock);
        for (int i = 0; i < 16; i++) if (d[i]) m_gpr[i] = b;
        if (d[D_HI])  m_hi  = b;
        if (d[D_LO])  m_lo  = b;
        if (d[D_PC])  m_pc  = b;
        if (d[D_IR])  m_ir  = b;
        if (d[D_MAR]) m_mar = b;
        if (d[D_Y])   m_y   = b;
        if (d[D_MDR]) m_mdr = rd ? md : b;
        if (d[D_INP]) m_inp = b;
        if (d[D_Z]) m_z = alu;
        else begin
            if (d[D_ZH]) m_z[63:32] = b;
            if (d[D_ZL]) m_z[31:0]  = b;
        end
    endtask

    task automatic mv(input logic [23:0] s, input logic [26:0] d, input logic [3:0] op);
        step(s, d, op, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic mem(input logic [31:0] md);
        step(24'd0, db(D_MDR), 4'd0, 1'b1, md, 1'b0, 32'd0);
    endtask

    task automatic observe(input logic [23:0] s, input logic [31:0] expv);
        step(s, db(D_INP), 4'd15, 1'b0, 32'd0, 1'b1, expv);
    endtask

    task automatic idle();
        @(negedge i_clock);
        i_r_in = '0; i_r_out = '0;
        {i_hi_in, i_lo_in, i_pc_in, i_ir_in, i_mar_in, i_y_in, i_zhigh_in, i_zlow_in, i_z_in} = '0;
        {i_mdr_in, i_read, i_in_port_in} = '0;
        {i_hi_out, i_lo_out, i_zhigh_out, i_zlow_out, i_pc_out, i_mdr_out, i_in_port_out, i_c_out} = '0;
    endtask

    // monitor: every In_Port load is compared against the queued expectation
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge i_clock);
            if (i_in_port_in && i_clear) begin
                @(negedge i_clock);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_port unexpected load: got %h, required none", o_out_portout);
                end else begin
                    e = exp_q.pop_front();
                    if (o_out_portout !== e) begin
                        n_fail++;
                        $display("FAIL out_port check %0d: got %h, required %h", n_checks, o_out_portout, e);
                    end
                end
            end
        end
    end

    task automatic random_steps(input int count);
        logic [23:0] s;
        logic [26:0] d;
        int r;
        for (int t = 0; t < count; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      s = 24'd0;
            else if (r == 1) s = sb(int'($urandom_range(0, 23))) | sb(int'($urandom_range(0, 23)));
            else             s = sb(int'($urandom_range(0, 23)));
            r = int'($urandom_range(0, 19));
            if (r < 6)       d = db(D_INP);
            else if (r < 9)  d = db(D_Y);
            else if (r < 13) d = db(D_Z);
            else if (r == 13) d = db(D_Z) | db(int'($urandom_range(D_ZH, D_ZL)));
            else             d = db(int'($urandom_range(0, 26)));
            step(s, d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, 1'b0, 32'd0);
        end
    endtask

    initial begin
        model_reset();
        #3;
        n_checks++;
        if (o_out_portout !== 32'd0) begin
            n_fail++;
            $display("FAIL reset out_port: got %h, required %h", o_out_portout, 32'd0);
        end
        @(negedge i_clock);
        i_clear = 1'b1;

        // memory loads into R2, R3, R1
        mem(32'h12); mv(sb(S_MDR), db(2), 4'd0);
        mem(32'h14); mv(sb(S_MDR), db(3), 4'd0);
        mem(32'h0);  mv(sb(S_MDR), db(1), 4'd0);
        observe(sb(2), 32'h12);
        observe(sb(3), 32'h14);
        observe(sb(1), 32'h0);

        // fetch: PC -> MAR, memory -> MDR -> IR; C is sign-extended IR[18:0]
        mv(sb(S_PC), db(D_MAR), 4'd0);
        mem(32'h2891_8000);
        mv(sb(S_MDR), db(D_IR), 4'd0);
        observe(sb(S_C), 32'h0001_8000);

        // AND / OR / NOT
        mv(sb(2), db(D_Y), 4'd0);
        mv(sb(3), db(D_Z), 4'd2); mv(sb(S_ZL), db(1), 4'd0);
        observe(sb(1), 32'h10);
        mv(sb(3), db(D_Z), 4'd3); mv(sb(S_ZL), db(4), 4'd0);
        observe(sb(4), 32'h16);
        mv(sb(2), db(D_Z), 4'd5); mv(sb(S_ZL), db(5), 4'd0);
        observe(sb(5), 32'hFFFF_FFED);

        // MUL 0x12 * 0x14
        mv(sb(3), db(D_Z), 4'd11);
        observe(sb(S_ZL), 32'h168);
        observe(sb(S_ZH), 32'h0);

        // DIV 0x14 / 0x12, then divide by zero (idle bus)
        mv(sb(3), db(D_Y), 4'd0);
        mv(sb(2), db(D_Z), 4'd12);
        observe(sb(S_ZL), 32'h1);
        observe(sb(S_ZH), 32'h2);
        mv(24'd0, db(D_Z), 4'd12);
        observe(sb(S_ZL), 32'hFFFF_FFFF);
        observe(sb(S_ZH), 32'h14);

        // signed MUL / DIV / shifts with negatives
        mem(32'hFFFF_FFF9); mv(sb(S_MDR), db(6), 4'd0);       // R6 = -7
        mv(sb(6), db(D_Y), 4'd0);                            // Y = -7
        mv(sb(2), db(D_Z), 4'd11);                           // -7 * 18
        observe(sb(S_ZL), 32'hFFFF_FF82);
        observe(sb(S_ZH), 32'hFFFF_FFFF);
        mem(32'h2); mv(sb(S_MDR), db(7), 4'd0);               // R7 = 2
        mv(sb(7), db(D_Z), 4'd12);                           // -7 / 2
        observe(sb(S_ZL), 32'hFFFF_FFFD);
        observe(sb(S_ZH), 32'hFFFF_FFFF);
        mv(sb(7), db(D_Z), 4'd7);                            // -7 >>> 2
        observe(sb(S_ZL), 32'hFFFF_FFFE);
        mv(sb(7), db(D_Z), 4'd9);                            // ror 2
        observe(sb(S_ZL), 32'h7FFF_FFFE);
        mv(sb(1), db(D_Z), 4'd10);                           // rol by 0x10[4:0]=16
        observe(sb(S_ZL), 32'hFFF9_FFFF);
        mem(32'h20); mv(sb(S_MDR), db(8), 4'd0);              // R8 = 32 -> shift amount 0
        mv(sb(8), db(D_Z), 4'd6);
        observe(sb(S_ZL), 32'hFFFF_FFF9);

        // bus priority and Zin over Zlowin
        observe(sb(2) | sb(3), 32'h12);
        observe(sb(S_HI) | sb(S_C), 32'h0);
        mv(sb(3), db(D_Y), 4'd0);
        mv(sb(3), db(D_Z) | db(D_ZL), 4'd0);
        observe(sb(S_ZL), 32'h28);

        // idle bus loads 0 into Y
        mv(24'd0, db(D_Y), 4'd0);
        mv(sb(3), db(D_Z), 4'd0);
        observe(sb(S_ZL), 32'h14);

        // In_Port
        mem(32'hA5);
        observe(sb(S_MDR), 32'hA5);

        random_steps(300);

        // asynchronous clear in the middle of a cycle
        mem(32'h5A5A_0001);
        observe(sb(S_MDR), 32'h5A5A_0001);
        idle();
        #2;
        i_clear = 1'b0;
        #1;
        n_checks++;
        if (o_out_portout !== 32'd0) begin
            n_fail++;
            $display("FAIL async clear out_port: got %h, required %h", o_out_portout, 32'd0);
        end
        model_reset();
        @(negedge i_clock);
        i_clear = 1'b1;
        observe(sb(2), 32'h0);
        observe(sb(S_MDR), 32'h0);
        mv(24'd0, db(D_Z), 4'd0);
        observe(sb(S_ZL), 32'h0);

        random_steps(400);
        idle();
        repeat (3) @(negedge i_clock);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pending expectations: got %0d left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
